game_controller: RTL and testbench

Central sequencer for the 8x8 minesweeper game. Owns the play-state matrix consumed by the VGA renderer and runs the game FSM: waits for bomb placement, applies select/flag commands at the cursor, flood-reveals zero regions by iterative sweeps, and detects win/loss. Sits between the cursor/button logic, the bomb/number generators and the VGA block, and replaces the stand-alone click handler.

---
 rtl/game_controller.sv | 132 +++++++++++++
 tb/tb_game_controller.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/game_controller.sv
// game_controller: 8x8 minesweeper sequencer that owns the play-state matrix.
// It handles select/flag commands, flood-reveals zero regions by sweeps, and detects win/loss.
module game_controller (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  bombs_ready,
  input  logic [5:0]            num_bombs,
  input  logic                  select,
  input  logic                  flag,
  input  logic [2:0]            pos_x,
  input  logic [2:0]            pos_y,
  input  logic [7:0][7:0][3:0]  m_num,
  output logic [7:0][7:0][3:0]  m_game,
  output logic [2:0]            state,
  output logic                  busy,
  output logic [5:0]            flags_left,
  output logic [6:0]            revealed
);
  typedef enum logic [2:0] {IDLE, WAIT, PLAY, SWEEP, SHOW, WON, LOST} state_t;
  state_t st, st_n;
  logic [7:0][7:0][3:0] game_n;
  logic [6:0] rev_n, target;
  logic [5:0] fl_n, nb, nb_n, idx, idx_n;
  logic chg, chg_n, sel_q, flg_q, sel_e, flg_e, nbr, upd;
  logic [9:0][9:0] zp;
  logic [3:0] cx, cy, cur, pnum, scur, snum;
  assign cx = {1'b0, idx[2:0]};
  assign cy = {1'b0, idx[5:3]};
  assign cur = m_game[pos_y][pos_x];
  assign pnum = m_num[pos_y][pos_x];
  assign scur = m_game[idx[5:3]][idx[2:0]];
  assign snum = m_num[idx[5:3]][idx[2:0]];
  assign target = 7'd64 - {1'b0, nb};
  assign sel_e = select & ~sel_q;
  assign flg_e = flag & ~flg_q;
  assign state = st;
  assign busy = st == SWEEP || st == SHOW;
  // Zero-padded map of revealed zero cells, so the 3x3 window never leaves the grid
  always_comb begin
    zp = '0;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        zp[y+1][x+1] = m_game[y][x] == 4'd1 && m_num[y][x] == 4'd0;
  end
  assign nbr = |{zp[cy][cx+:3], zp[cy+4'd1][cx+:3], zp[cy+4'd2][cx+:3]};
  assign upd = st == SWEEP && scur == 4'd0 && nbr;
  always_comb begin
    st_n = st;
    game_n = m_game;
    rev_n = revealed;
    fl_n = flags_left;
    nb_n = nb;
    idx_n = idx;
    chg_n = chg;
    if (start) begin
      st_n = WAIT;
      game_n = '0;
      rev_n = '0;
      nb_n = num_bombs;
      fl_n = num_bombs;
      idx_n = '0;
      chg_n = 1'b0;
    end else begin
      case (st)
        WAIT: st_n = bombs_ready ? PLAY : WAIT;
        PLAY: begin
          idx_n = '0;
          chg_n = 1'b0;
          if (sel_e) begin
            if (cur == 4'd0 && pnum == 4'd9) begin
              game_n[pos_y][pos_x] = 4'd3;
              st_n = SHOW;
            end else if (cur == 4'd0) begin
              game_n[pos_y][pos_x] = 4'd1;
              rev_n = revealed + 7'd1;
              st_n = pnum == 4'd0 ? SWEEP : (rev_n == target ? WON : PLAY);
            end
          end else if (flg_e) begin
            if (cur == 4'd0 && flags_left != 6'd0) begin
              game_n[pos_y][pos_x] = 4'd2;
              fl_n = flags_left - 6'd1;
            end else if (cur == 4'd2) begin
              game_n[pos_y][pos_x] = 4'd0;
              fl_n = flags_left + 6'd1;
            end
          end
        end
        SWEEP: begin
          if (upd) begin
            game_n[idx[5:3]][idx[2:0]] = 4'd1;
            rev_n = revealed + 7'd1;
          end
          idx_n = idx + 6'd1;
          chg_n = idx == 6'd63 ? 1'b0 : chg | upd;
          if (idx == 6'd63 && !(chg | upd))
            st_n = rev_n == target ? WON : PLAY;
        end
        SHOW: begin
          if (scur == 4'd0 && snum == 4'd9)
            game_n[idx[5:3]][idx[2:0]] = 4'd3;
          idx_n = idx + 6'd1;
          st_n = idx == 6'd63 ? LOST : SHOW;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= IDLE;
      m_game <= '0;
      revealed <= '0;
      flags_left <= '0;
      nb <= '0;
      idx <= '0;
      chg <= 1'b0;
      sel_q <= 1'b0;
      flg_q <= 1'b0;
    end else begin
      st <= st_n;
      m_game <= game_n;
      revealed <= rev_n;
      flags_left <= fl_n;
      nb <= nb_n;
      idx <= idx_n;
      chg <= chg_n;
      sel_q <= select;
      flg_q <= flag;
    end
  end
endmodule

// File: tb/tb_game_controller.sv
// tb_game_controller: directed checks of game_controller against hand-computed results.
module tb_game_controller;
  logic clk = 0, rst = 1, start = 0, bombs_ready = 1, select = 0, flag = 0;
  logic [5:0] num_bombs = 0;
  logic [2:0] pos_x = 0, pos_y = 0;
  logic [7:0][7:0][3:0] m_num = '0;
  logic [7:0][7:0][3:0] m_game;
  logic [2:0] state;
  logic busy;
  logic [5:0] flags_left;
  logic [6:0] revealed;
  int total = 0, bad = 0, n;

  always #5 clk = ~clk;

  game_controller dut (
    .clk(clk), .rst(rst), .start(start), .bombs_ready(bombs_ready),
    .num_bombs(num_bombs), .select(select), .flag(flag),
    .pos_x(pos_x), .pos_y(pos_y), .m_num(m_num), .m_game(m_game),
    .state(state), .busy(busy), .flags_left(flags_left), .revealed(revealed)
  );

  task tick;
    @(posedge clk);
    #1;
  endtask

  task chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] at(input int x, input int y);
    return 64'd1 << (y * 8 + x);
  endfunction

  // Reference number generator: 9 for a bomb, otherwise count of in-grid bomb neighbours
  task automatic place(input logic [63:0] bm);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) begin
        int c = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if (x + dx >= 0 && x + dx < 8 && y + dy >= 0 && y + dy < 8 && bm[(y + dy) * 8 + x + dx])
              c++;
        m_num[y][x] = bm[y * 8 + x] ? 4'd9 : 4'(c);
      end
  endtask

  task go(input logic [5:0] nb);
    num_bombs = nb;
    start = 1;
    tick;
    start = 0;
  endtask

  task btn(input logic [2:0] x, input logic [2:0] y, input logic s, input logic f);
    pos_x = x;
    pos_y = y;
    select = 0;
    flag = 0;
    tick;
    select = s;
    flag = f;
    tick;
    select = 0;
    flag = 0;
  endtask

  task run(input logic [2:0] s, output int cnt);
    cnt = 0;
    while (state == s && cnt < 1000) begin
      cnt++;
      tick;
    end
  endtask

  initial begin
    #2 rst = 0;
    #1;
    chk("rst_game", m_game, '0);
    chk("rst_state", state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", flags_left, 0);
    chk("rst_rev", revealed, 0);
    #19 rst = 1;
    tick;
    chk("idle_hold", state, 0);

    place(at(1,2) | at(3,4) | at(7,0) | at(7,1) | at(6,0) | at(0,7) | at(1,7) | at(7,7) | at(6,7) | at(5,0));
    go(10);
    chk("wait_state", state, 1);
    chk("wait_flags", flags_left, 10);
    tick;
    chk("play_state", state, 2);
    btn(2, 3, 1, 0);
    chk("sel_cell", m_game[3][2], 1);
    chk("sel_rev", revealed, 1);
    chk("sel_state", state, 2);
    btn(2, 3, 1, 0);
    chk("resel_cell", m_game[3][2], 1);
    chk("resel_rev", revealed, 1);
    btn(0, 0, 0, 1);
    chk("flag_cell", m_game[0][0], 2);
    chk("flag_cnt", flags_left, 9);
    btn(0, 0, 0, 1);
    chk("unflag_cell", m_game[0][0], 0);
    chk("unflag_cnt", flags_left, 10);
    btn(0, 0, 0, 1);
    btn(0, 0, 1, 0);
    chk("selflag_cell", m_game[0][0], 2);
    chk("selflag_rev", revealed, 1);
    btn(0, 1, 1, 1);
    chk("both_cell", m_game[1][0], 1);
    chk("both_flags", flags_left, 9);
    chk("both_rev", revealed, 2);

    go(0);
    tick;
    chk("nb0_state", state, 2);
    chk("nb0_clear", m_game, '0);
    btn(4, 4, 0, 1);
    chk("noflag_cell", m_game[4][4], 0);
    chk("noflag_cnt", flags_left, 0);

    place(at(7,7));
    go(1);
    tick;
    btn(0, 0, 1, 0);
    chk("sweep_enter", state, 3);
    chk("sweep_busy", busy, 1);
    run(3, n);
    chk("sweep_len", n, 128);
    chk("sweep_won", state, 5);
    chk("sweep_rev", revealed, 63);
    chk("sweep_bomb", m_game[7][7], 0);
    chk("sweep_busy_off", busy, 0);
    btn(7, 7, 1, 0);
    chk("won_frozen", m_game[7][7], 0);
    chk("won_state", state, 5);

    go(1);
    tick;
    btn(0, 0, 1, 0);
    tick;
    tick;
    #2 rst = 0;
    #1;
    chk("arst_game", m_game, '0);
    chk("arst_state", state, 0);
    chk("arst_rev", revealed, 0);
    chk("arst_busy", busy, 0);
    #1 rst = 1;
    tick;
    chk("arst_idle", state, 0);

    place(at(1,1) | at(3,3) | at(6,0) | at(0,6) | at(5,5));
    go(5);
    tick;
    btn(1, 1, 0, 1);
    chk("show_flag", m_game[1][1], 2);
    chk("show_flagcnt", flags_left, 4);
    btn(3, 3, 1, 0);
    chk("show_hit", m_game[3][3], 3);
    chk("show_state", state, 4);
    chk("show_busy", busy, 1);
    run(4, n);
    chk("show_len", n, 64);
    chk("show_lost", state, 6);
    chk("show_flagkeep", m_game[1][1], 2);
    chk("show_b60", m_game[0][6], 3);
    chk("show_b06", m_game[6][0], 3);
    chk("show_b55", m_game[5][5], 3);
    chk("show_safe", m_game[0][0], 0);
    btn(7, 3, 1, 0);
    chk("lost_frozen", m_game[3][7], 0);
    chk("lost_state", state, 6);

    place(64'h0000_0000_00FF_0000);
    go(8);
    tick;
    btn(0, 0, 1, 0);
    chk("wall_enter", state, 3);
    run(3, n);
    chk("wall_len", n, 128);
    chk("wall_state", state, 2);
    chk("wall_rev", revealed, 16);
    for (int x = 0; x < 4; x++) btn(3'(x), 3, 1, 0);
    chk("wall_rev20", revealed, 20);
    go(8);
    chk("restart_state", state, 1);
    chk("restart_rev", revealed, 0);
    chk("restart_game", m_game, '0);
    chk("restart_flags", flags_left, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
